// File: rtl/dirctrl.sv
// Direction/speed controller: decodes a 3-bit drive command into a pair of
// opposing signed motor set-points, registered with one clock of latency.
module dirctrl #(
    parameter int WIDTH    = 16,
    parameter int SPD_LOW  = 102,
    parameter int SPD_MID  = 218,
    parameter int SPD_HIGH = 402
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [2:0]       cmds,
    output logic [WIDTH-1:0] left_frwd,
    output logic [WIDTH-1:0] right_back
);

    logic [WIDTH-1:0] mag;
    logic [WIDTH-1:0] neg_mag;
    logic [WIDTH-1:0] left_next;
    logic [WIDTH-1:0] right_next;
    logic [WIDTH-1:0] left_reg;
    logic [WIDTH-1:0] right_reg;

    always_comb begin
        mag = '0;
        case (cmds[1:0])
            2'b00:   mag = '0;
            2'b01:   mag = WIDTH'(SPD_LOW);
            2'b10:   mag = WIDTH'(SPD_MID);
            default: mag = WIDTH'(SPD_HIGH);
        endcase
    end

    // Two's complement of zero wraps back to zero, so speed 0 needs no special case.
    assign neg_mag = ~mag + WIDTH'(1);

    always_comb begin
        left_next  = neg_mag;
        right_next = mag;
        if (cmds[2]) begin
            left_next  = mag;
            right_next = neg_mag;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            left_reg  <= '0;
            right_reg <= '0;
        end else begin
            left_reg  <= left_next;
            right_reg <= right_next;
        end
    end

    assign left_frwd  = left_reg;
    assign right_back = right_reg;

endmodule

// File: tb/tb_dirctrl.sv
// Directed bench for dirctrl: vector table for the decode sweeps plus
// hand-written sequences for latency, throughput and asynchronous reset.
module tb_dirctrl;

    logic        clk;
    logic        resetn;
    logic [2:0]  cmds;
    logic [15:0] left_frwd;
    logic [15:0] right_back;

    int checks = 0;
    int errors = 0;

    dirctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .cmds       (cmds),
        .left_frwd  (left_frwd),
        .right_back (right_back)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  cmds;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [15:0] exp_l, input logic [15:0] exp_r);
        checks++;
        if (left_frwd !== exp_l) begin
            errors++;
            $display("FAIL %s left_frwd: got %h expected %h", name, left_frwd, exp_l);
        end
        checks++;
        if (right_back !== exp_r) begin
            errors++;
            $display("FAIL %s right_back: got %h expected %h", name, right_back, exp_r);
        end
        $display("txn %-14s cmds=%b left=%h right=%h", name, cmds, left_frwd, right_back);
    endtask

    // Advance one active edge and sample just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{"rev_low",   3'b001, 16'hFF9A, 16'd102};
        vecs[1] = '{"rev_mid",   3'b010, 16'hFF26, 16'd218};
        vecs[2] = '{"rev_high",  3'b011, 16'hFE6E, 16'd402};
        vecs[3] = '{"fwd_low",   3'b101, 16'd102,  16'hFF9A};
        vecs[4] = '{"fwd_mid",   3'b110, 16'd218,  16'hFF26};
        vecs[5] = '{"fwd_high",  3'b111, 16'd402,  16'hFE6E};
        vecs[6] = '{"fwd_zero",  3'b100, 16'h0000, 16'h0000};

        // Reset held across two edges with a non-zero command.
        resetn = 1'b0;
        cmds   = 3'b111;
        #1;
        check("reset_async", 16'h0000, 16'h0000);
        step();
        step();
        check("reset_held", 16'h0000, 16'h0000);

        @(negedge clk);
        resetn = 1'b1;
        cmds   = 3'b000;
        step();
        check("release_zero", 16'h0000, 16'h0000);

        // Sweeps: each command held two cycles, checked after each edge.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            cmds = vecs[i].cmds;
            for (int h = 0; h < 2; h++) begin
                step();
                check(vecs[i].name, vecs[i].exp_l, vecs[i].exp_r);
            end
        end

        // Outputs must not move before the capturing edge.
        @(negedge clk);
        cmds = 3'b011;
        #1;
        check("pre_edge_hold", 16'h0000, 16'h0000);

        // Full throughput: a new command every cycle.
        step();
        check("tput_011", 16'hFE6E, 16'd402);
        @(negedge clk);
        cmds = 3'b111;
        step();
        check("tput_111", 16'd402, 16'hFE6E);
        @(negedge clk);
        cmds = 3'b000;
        step();
        check("tput_000", 16'h0000, 16'h0000);

        // Mid-run reset pulsed between edges.
        @(negedge clk);
        cmds = 3'b111;
        step();
        check("pre_reset", 16'd402, 16'hFE6E);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("midrun_reset", 16'h0000, 16'h0000);
        #1;
        resetn = 1'b1;
        #0.5;
        check("released", 16'h0000, 16'h0000);
        step();
        check("resume", 16'd402, 16'hFE6E);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
